// File: rtl/memory_stage_module.sv
// memory_stage_module
//   Memory + writeback stage of the 5-stage RISC-V pipeline. Holds the
//   word-addressed data memory, the M/W pipeline register and the writeback
//   result mux. ResultW/RdW/RegWriteW feed the register file and forwarding.
// Ports
//   clk, rst          clock; asynchronous active-low reset (clears W register only)
//   RegWriteM         instruction in M writes the register file
//   ResultSrcM        0 = ALU result, 1 = memory read data to writeback
//   MemWriteM         store enable
//   ALUResultM        byte address for load/store, also the ALU result
//   WriteDataM        store data
//   RdM, PCPlus4M     destination register / PC+4 of instruction in M
//   ReadDataM         combinational data-memory read word
//   RegWriteW, RdW    register-file write enable / address
//   ResultW           register-file write data
//   PCPlus4W          PC+4 of instruction in W
module memory_stage_module #(
  parameter int DMEM_DEPTH = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic [31:0] ReadDataM,
  output logic        RegWriteW,
  output logic [4:0]  RdW,
  output logic [31:0] ResultW,
  output logic [31:0] PCPlus4W
);

  typedef struct packed {
    logic        reg_write;
    logic        result_src;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } mw_reg_t;

  // Word index: byte-offset bits and anything above the array size are
  // dropped, so addresses alias modulo 4*DMEM_DEPTH.
  logic [ADDR_W-1:0] widx;
  assign widx = ALUResultM[ADDR_W+1:2];

  // Data memory. Not reset; a store is only taken on an edge where rst is
  // high, so a store in flight when reset asserts is dropped.
  logic [31:0] mem_q [DMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (rst && MemWriteM) mem_q[widx] <= WriteDataM;
  end

  // Combinational read sees the pre-edge contents on a same-edge store.
  assign ReadDataM = mem_q[widx];

  // M/W pipeline register
  mw_reg_t mw_d, mw_q;

  always_comb begin
    mw_d            = '0;
    // x0 writes are squashed so forwarding can never match x0.
    mw_d.reg_write  = RegWriteM & (RdM != 5'd0);
    mw_d.result_src = ResultSrcM;
    mw_d.alu_result = ALUResultM;
    mw_d.read_data  = ReadDataM;
    mw_d.rd         = RdM;
    mw_d.pc_plus4   = PCPlus4M;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mw_q <= '0;
    else      mw_q <= mw_d;
  end

  // Writeback mux
  assign ResultW   = mw_q.result_src ? mw_q.read_data : mw_q.alu_result;
  assign RegWriteW = mw_q.reg_write;
  assign RdW       = mw_q.rd;
  assign PCPlus4W  = mw_q.pc_plus4;

endmodule
